// File: rtl/vending_machine.sv
// Three-unit vending FSM with registered dispense and change pulses.
// Optional VENDING_SALES_COUNT_EN adds an 8-bit wrapping sales counter.
module vending_machine #(
  parameter int PRICE = 3
) (
  output logic       choco_out,
  output logic       chng_out,
  input  logic       clk,
  input  logic       reset,
  input  logic       two_in,
  input  logic       one_in
`ifdef VENDING_SALES_COUNT_EN
  ,
  output logic [7:0] sales_cnt
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  localparam logic [2:0] PRICE_W = 3'(PRICE);
  localparam logic [2:0] OVER_W  = 3'(PRICE + 1);

  state_t     state_q, state_d;
  logic       choco_q, choco_d;
  logic       chng_q, chng_d;
  logic [2:0] coin;
  logic [2:0] sum;

  // two_in wins when both are high
  always_comb begin
    coin = 3'd0;
    if (two_in) begin
      coin = 3'd2;
    end else if (one_in) begin
      coin = 3'd1;
    end
  end

  assign sum = {1'b0, state_q} + coin;

  always_comb begin
    state_d = S0;
    choco_d = 1'b0;
    chng_d  = 1'b0;
    case (state_q)
      S0, S1, S2: begin
        if (sum < PRICE_W) begin
          state_d = state_t'(sum[1:0]);
        end else if (sum == PRICE_W) begin
          choco_d = 1'b1;
        end else if (sum == OVER_W) begin
          choco_d = 1'b1;
          chng_d  = 1'b1;
        end
      end
      default: begin
        state_d = S0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
      choco_q <= 1'b0;
      chng_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      choco_q <= choco_d;
      chng_q  <= chng_d;
    end
  end

  assign choco_out = choco_q;
  assign chng_out  = chng_q;

`ifdef VENDING_SALES_COUNT_EN
  logic [7:0] sales_q, sales_d;

  // counts alongside the pulse, so it steps on the same edge
  always_comb begin
    sales_d = sales_q;
    if (choco_d) begin
      sales_d = sales_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sales_q <= 8'd0;
    end else begin
      sales_q <= sales_d;
    end
  end

  assign sales_cnt = sales_q;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed table-driven bench for vending_machine.
// Covers credit paths, change, reset loss and optional sales counter.
module tb_vending_machine;

  logic clk;
  logic reset;
  logic two_in;
  logic one_in;
  logic choco_out;
  logic chng_out;
`ifdef VENDING_SALES_COUNT_EN
  logic [7:0] sales_cnt;
  logic [7:0] exp_sales;
`endif

  int nvec;
  int nbad;

  vending_machine #(.PRICE(3)) dut (
    .choco_out (choco_out),
    .chng_out  (chng_out),
    .clk       (clk),
    .reset     (reset),
    .two_in    (two_in),
    .one_in    (one_in)
`ifdef VENDING_SALES_COUNT_EN
    ,
    .sales_cnt (sales_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic two;
    logic one;
    logic choco;
    logic chng;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic step(
    input logic  r,
    input logic  t,
    input logic  o,
    input logic  ec,
    input logic  eh,
    input string name
  );
    reset  = r;
    two_in = t;
    one_in = o;
    @(posedge clk);
    #1;
    nvec++;
    if (choco_out !== ec || chng_out !== eh) begin
      nbad++;
      $display("FAIL %s: choco/chng got %b%b want %b%b",
               name, choco_out, chng_out, ec, eh);
    end
`ifdef VENDING_SALES_COUNT_EN
    if (!r) begin
      exp_sales = 8'd0;
    end else if (ec) begin
      exp_sales = exp_sales + 8'd1;
    end
    nvec++;
    if (sales_cnt !== exp_sales) begin
      nbad++;
      $display("FAIL %s sales_cnt: got %0d want %0d",
               name, sales_cnt, exp_sales);
    end
`endif
  endtask

  initial begin
    nvec   = 0;
    nbad   = 0;
    reset  = 1'b0;
    two_in = 1'b0;
    one_in = 1'b0;
`ifdef VENDING_SALES_COUNT_EN
    exp_sales = 8'd0;
`endif

    //            rst  two  one  choco chng
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].two, vecs[i].one,
           vecs[i].choco, vecs[i].chng, $sformatf("vec%0d", i));
    end

    // held one_in level: every third edge buys, no change
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, (i % 3 == 2), 1'b0,
           $sformatf("hold_one%0d", i));
    end

    // S1 then reset while a coin is held: credit and coin lost
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pre_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_coin");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_two");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_keep");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "s2_plus_two");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pulse_end");

`ifdef VENDING_SALES_COUNT_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sales_rst");
    for (int i = 0; i < 768; i++) begin
      step(1'b1, 1'b0, 1'b1, (i % 3 == 2), 1'b0,
           $sformatf("sales%0d", i));
    end
    nvec++;
    if (sales_cnt !== 8'd0) begin
      nbad++;
      $display("FAIL sales_wrap: got %0d want 0", sales_cnt);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sales_s1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "sales_one");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sales_clear");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 Parameters: PRICE, 3, item price in coin units (fixed at 3; other values not supported).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 Port: two_in  input  1  two-unit coin present this cycle (level, sampled per clock).
REQ-005 Port: one_in  input  1  one-unit coin present this cycle (level, sampled per clock).
REQ-006 Port: choco_out  output  1  registered one-cycle pulse: item dispensed.
REQ-007 Port: chng_out  output  1  registered one-cycle pulse: one unit of change returned.
REQ-008 Port order SHALL be choco_out, chng_out, clk, reset, two_in, one_in.

Function
REQ-009 Each rising edge with a coin input high SHALL count as exactly one coin; a level held for N cycles counts as N coins.
REQ-010 two_in and one_in both high in one cycle SHALL count as a single two-unit coin; one_in is ignored that cycle.
REQ-011 Credit states SHALL be S0 (0), S1 (1), S2 (2), encoded in a 2-bit state register.
REQ-012 Coin value SHALL be 2 if two_in, else 1 if one_in, else 0; sum = credit + coin value (3-bit, max 4).
REQ-013 sum < 3: next state is S(sum), choco_out=0, chng_out=0 next cycle.
REQ-014 sum == 3: next state S0, choco_out=1, chng_out=0 for the following cycle only.
REQ-015 sum == 4 (S2 plus two-unit coin): next state S0, choco_out=1, chng_out=1 for the following cycle only.
REQ-016 Outputs SHALL be registered: a pulse appears one clock after the coin-sampling edge and lasts exactly one cycle.
REQ-017 No coin: state holds and outputs are 0; credit never times out.
REQ-018 A coin arriving in the cycle a pulse is output SHALL be credited normally starting from S0.
REQ-019 chng_out SHALL never assert without choco_out in the same cycle.
REQ-020 Unreachable state encoding (3) SHALL transition to S0 with outputs 0.

Reset
REQ-021 reset==0 at a rising edge SHALL force state S0, choco_out=0, chng_out=0, discarding credit and coins that cycle.
REQ-022 Reset mid-transaction SHALL lose accumulated credit with no change pulse.
REQ-023 No asynchronous reset path; outputs hold until the next clock edge.

Configuration
REQ-024 Macro VENDING_SALES_COUNT_EN defined: add output port sales_cnt (8-bit, after one_in) counting choco_out pulses, wrapping 255->0, cleared to 0 by reset.
REQ-025 Macro undefined: no sales_cnt port or counter; all other behaviour identical.

Verification
REQ-026 reset=0 two cycles, then reset=1, no coins -> choco_out=0, chng_out=0, state S0.
REQ-027 one_in high 3 consecutive cycles -> choco_out=1, chng_out=0 one cycle after third edge; state S0.
REQ-028 two_in high 2 consecutive cycles -> choco_out=1 and chng_out=1 one cycle after second edge.
REQ-029 one_in 1 cycle, idle 2 cycles, two_in 1 cycle -> choco_out=1, chng_out=0; idle gaps retain credit.
REQ-030 two_in and one_in both high 2 cycles -> treated as 2+2: choco_out=1, chng_out=1; then reset=0 after one one_in -> no pulses, credit 0.
REQ-031 With VENDING_SALES_COUNT_EN: 256 purchases -> sales_cnt wraps to 0; reset clears it.
